// File: rtl/flush_controller.sv
// Pipeline flush / fetch-redirect sequencer: flushes on exception or ERET, drains in-flight fetches,
// then offers the redirect PC. Optional FLUSH_CONTROLLER_STATS_EN adds a flush event counter.
module flush_controller #(
    parameter logic [31:0] EXCEPTION_ENTRY = 32'hBFC0_0380,
    parameter int unsigned MAX_OUTSTANDING = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_exception_valid,
    input  logic        wb_eret_flush,
    input  logic [31:0] cp0_epc,
    input  logic        fetch_request_accepted,
    input  logic        fetch_response_valid,
    input  logic        redirect_ready,
    output logic        pipeline_flush,
    output logic        fetch_hold,
    output logic        fetch_full,
    output logic        discard_response,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
`ifdef FLUSH_CONTROLLER_STATS_EN
    output logic [31:0] flush_count,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StDrain, StRedirect} state_e;

    localparam logic [2:0] MaxCount = MAX_OUTSTANDING[2:0];

    state_e      state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        flush_event;

    assign flush_event = wb_exception_valid || wb_eret_flush;

    // Simultaneous request and response cancel; saturate at both ends.
    always_comb begin
        count_d = count_q;
        if (fetch_request_accepted && !fetch_response_valid) begin
            if (count_q != 3'd7) count_d = count_q + 3'd1;
        end else if (!fetch_request_accepted && fetch_response_valid) begin
            if (count_q != 3'd0) count_d = count_q - 3'd1;
        end
    end

    always_comb begin
        state_d        = state_q;
        redirect_pc_d  = redirect_pc_q;
        pipeline_flush = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (flush_event) begin
                    pipeline_flush = 1'b1;
                    state_d        = StDrain;
                    redirect_pc_d  = wb_exception_valid ? EXCEPTION_ENTRY : cp0_epc;
                end
            end
            StDrain: begin
                // Leave in the same cycle the last pending response arrives.
                if (count_q == 3'd0 || (count_q == 3'd1 && fetch_response_valid)) begin
                    state_d = StRedirect;
                end
            end
            StRedirect: begin
                if (redirect_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            count_q       <= 3'd0;
            redirect_pc_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign fetch_hold       = pipeline_flush || (state_q != StIdle);
    assign fetch_full       = (count_q == MaxCount);
    assign discard_response = (state_q == StDrain) && fetch_response_valid;
    assign redirect_valid   = (state_q == StRedirect);
    assign redirect_pc      = redirect_pc_q;
    assign busy             = (state_q != StIdle);

`ifdef FLUSH_CONTROLLER_STATS_EN
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        flush_count_d = flush_count_q;
        if (pipeline_flush) flush_count_d = flush_count_q + 32'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flush_count_q <= 32'h0;
        end else begin
            flush_count_q <= flush_count_d;
        end
    end

    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_flush_controller.sv
// Self-checking bench for flush_controller: directed scenarios plus randomized traffic checked
// against a transaction-level model of the flush/drain/redirect sequence.
module tb_flush_controller;

    localparam logic [31:0] Entry = 32'hBFC0_0380;
    localparam int          MaxOut = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wb_exception_valid = 1'b0;
    logic        wb_eret_flush = 1'b0;
    logic [31:0] cp0_epc = 32'h0;
    logic        fetch_request_accepted = 1'b0;
    logic        fetch_response_valid = 1'b0;
    logic        redirect_ready = 1'b0;
    logic        pipeline_flush, fetch_hold, fetch_full, discard_response, redirect_valid, busy;
    logic [31:0] redirect_pc;
`ifdef FLUSH_CONTROLLER_STATS_EN
    logic [31:0] flush_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: pending-fetch tally plus "busy" / "still draining" flags.
    int          m_count;
    bit          m_busy, m_drain;
    logic [31:0] m_pc;
    logic [31:0] m_flushes;

    flush_controller #(
        .EXCEPTION_ENTRY(Entry),
        .MAX_OUTSTANDING(MaxOut)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .wb_exception_valid    (wb_exception_valid),
        .wb_eret_flush         (wb_eret_flush),
        .cp0_epc               (cp0_epc),
        .fetch_request_accepted(fetch_request_accepted),
        .fetch_response_valid  (fetch_response_valid),
        .redirect_ready        (redirect_ready),
        .pipeline_flush        (pipeline_flush),
        .fetch_hold            (fetch_hold),
        .fetch_full            (fetch_full),
        .discard_response      (discard_response),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
`ifdef FLUSH_CONTROLLER_STATS_EN
        .flush_count           (flush_count),
`endif
        .busy                  (busy)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        @(negedge clock);
    endtask

    task automatic clear_inputs;
        wb_exception_valid     = 1'b0;
        wb_eret_flush          = 1'b0;
        fetch_request_accepted = 1'b0;
        fetch_response_valid   = 1'b0;
        redirect_ready         = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1'b1;
        #13;
        reset = 1'b0;
        tick();
        m_count = 0; m_busy = 0; m_drain = 0; m_pc = 32'h0; m_flushes = 32'h0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step;
        bit ev;
        ev = wb_exception_valid || wb_eret_flush;
        if (!m_busy && ev) begin
            m_busy = 1; m_drain = 1; m_flushes = m_flushes + 32'd1;
            m_pc = wb_exception_valid ? Entry : cp0_epc;
        end else if (m_drain) begin
            if (m_count - (fetch_response_valid ? 1 : 0) <= 0) m_drain = 0;
        end else if (m_busy && redirect_ready) begin
            m_busy = 0;
        end
        if (fetch_request_accepted && !fetch_response_valid) m_count = (m_count < 7) ? m_count + 1 : 7;
        else if (!fetch_request_accepted && fetch_response_valid) m_count = (m_count > 0) ? m_count - 1 : 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b1;
        #3;
        checks++; if ({pipeline_flush, fetch_hold, fetch_full, discard_response, redirect_valid, busy} !== 6'b0) begin
            errors++; $display("FAIL reset_outputs: got %b want 000000",
                {pipeline_flush, fetch_hold, fetch_full, discard_response, redirect_valid, busy});
        end
        checks++; if (redirect_pc !== 32'h0) begin
            errors++; $display("FAIL reset_pc: got %h want 00000000", redirect_pc);
        end
        #10;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_exception;
        wb_exception_valid = 1'b1;
        settle();
        checks++; if ({pipeline_flush, fetch_hold, busy} !== 3'b110) begin
            errors++; $display("FAIL exc_T: got flush/hold/busy=%b want 110", {pipeline_flush, fetch_hold, busy});
        end
        tick();
        wb_exception_valid = 1'b0;
        settle();
        checks++; if ({pipeline_flush, busy, redirect_valid} !== 3'b010) begin
            errors++; $display("FAIL exc_T1: got flush/busy/rv=%b want 010", {pipeline_flush, busy, redirect_valid});
        end
        tick();
        settle();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== Entry) begin
            errors++; $display("FAIL exc_T2: got rv=%b pc=%h want 1 %h", redirect_valid, redirect_pc, Entry);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        settle();
        checks++; if (busy !== 1'b0 || fetch_hold !== 1'b0) begin
            errors++; $display("FAIL exc_T3: got busy=%b hold=%b want 0 0", busy, fetch_hold);
        end
        tick();
    endtask

    task automatic test_eret_drain;
        fetch_request_accepted = 1'b1;
        tick(); tick();
        fetch_request_accepted = 1'b0;
        wb_eret_flush = 1'b1;
        cp0_epc       = 32'hBFC0_1234;
        tick();
        wb_eret_flush = 1'b0;
        cp0_epc       = 32'hDEAD_BEEF;
        tick();
        fetch_response_valid = 1'b1;
        settle();
        checks++; if (discard_response !== 1'b1) begin
            errors++; $display("FAIL eret_discard1: got %b want 1", discard_response);
        end
        tick();
        fetch_response_valid = 1'b0;
        tick();
        fetch_response_valid = 1'b1;
        settle();
        checks++; if (discard_response !== 1'b1 || redirect_valid !== 1'b0) begin
            errors++; $display("FAIL eret_discard2: got discard=%b rv=%b want 1 0", discard_response, redirect_valid);
        end
        tick();
        fetch_response_valid = 1'b0;
        settle();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC0_1234) begin
            errors++; $display("FAIL eret_T5: got rv=%b pc=%h want 1 bfc01234", redirect_valid, redirect_pc);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
    endtask

    task automatic test_both_events;
        wb_exception_valid = 1'b1;
        wb_eret_flush      = 1'b1;
        cp0_epc            = 32'h1234_5678;
        tick();
        clear_inputs();
        tick();
        settle();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== Entry) begin
            errors++; $display("FAIL both_pc: got rv=%b pc=%h want 1 %h", redirect_valid, redirect_pc, Entry);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
    endtask

    task automatic test_full;
        fetch_request_accepted = 1'b1;
        tick(); tick();
        settle();
        checks++; if (fetch_full !== 1'b0) begin
            errors++; $display("FAIL full_at2: got %b want 0", fetch_full);
        end
        tick();
        fetch_request_accepted = 1'b0;
        settle();
        checks++; if (fetch_full !== 1'b1) begin
            errors++; $display("FAIL full_at3: got %b want 1", fetch_full);
        end
        fetch_request_accepted = 1'b1;
        fetch_response_valid   = 1'b1;
        tick();
        fetch_request_accepted = 1'b0;
        fetch_response_valid   = 1'b0;
        settle();
        checks++; if (fetch_full !== 1'b1) begin
            errors++; $display("FAIL full_req_resp: got %b want 1", fetch_full);
        end
        // Three real responses plus one spurious one at count 0.
        fetch_response_valid = 1'b1;
        tick(); tick(); tick(); tick();
        fetch_response_valid = 1'b0;
        settle();
        checks++; if (fetch_full !== 1'b0) begin
            errors++; $display("FAIL full_drained: got %b want 0", fetch_full);
        end
        wb_exception_valid = 1'b1;
        tick();
        wb_exception_valid = 1'b0;
        tick();
        settle();
        checks++; if (redirect_valid !== 1'b1) begin
            errors++; $display("FAIL no_underflow: got rv=%b want 1", redirect_valid);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
    endtask

    task automatic test_async_reset;
        fetch_request_accepted = 1'b1;
        tick(); tick();
        fetch_request_accepted = 1'b0;
        wb_exception_valid = 1'b1;
        tick();
        wb_exception_valid   = 1'b0;
        fetch_response_valid = 1'b1;
        #2;
        checks++; if (busy !== 1'b1 || discard_response !== 1'b1) begin
            errors++; $display("FAIL arst_pre: got busy=%b discard=%b want 1 1", busy, discard_response);
        end
        reset = 1'b1;
        #1;
        checks++; if ({pipeline_flush, fetch_hold, fetch_full, discard_response, redirect_valid, busy} !== 6'b0
                      || redirect_pc !== 32'h0) begin
            errors++; $display("FAIL arst_now: got %b pc=%h want 000000 00000000",
                {pipeline_flush, fetch_hold, fetch_full, discard_response, redirect_valid, busy}, redirect_pc);
        end
        fetch_response_valid = 1'b0;
        #4;
        reset = 1'b0;
        tick();
        wb_exception_valid = 1'b1;
        tick();
        wb_exception_valid = 1'b0;
        tick();
        settle();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== Entry) begin
            errors++; $display("FAIL arst_after: got rv=%b pc=%h want 1 %h", redirect_valid, redirect_pc, Entry);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
    endtask

    task automatic test_random;
        bit e_flush, e_hold, e_discard, e_rv, e_full;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            wb_exception_valid     = ($urandom_range(9) == 0);
            wb_eret_flush          = ($urandom_range(7) == 0);
            cp0_epc                = $urandom;
            fetch_response_valid   = (m_count > 0) ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
            fetch_request_accepted = !m_busy && !wb_exception_valid && !wb_eret_flush && m_count < MaxOut
                                     && ($urandom_range(1) == 0);
            redirect_ready         = $urandom_range(1);
            e_flush   = !m_busy && (wb_exception_valid || wb_eret_flush);
            e_hold    = e_flush || m_busy;
            e_discard = m_drain && fetch_response_valid;
            e_rv      = m_busy && !m_drain;
            e_full    = (m_count == MaxOut);
            settle();
            checks++; if ({pipeline_flush, fetch_hold, discard_response, redirect_valid, fetch_full, busy}
                          !== {e_flush, e_hold, e_discard, e_rv, e_full, m_busy}) begin
                errors++; $display("FAIL rand_outputs[%0d]: got %b want %b", i,
                    {pipeline_flush, fetch_hold, discard_response, redirect_valid, fetch_full, busy},
                    {e_flush, e_hold, e_discard, e_rv, e_full, m_busy});
            end
            checks++; if (redirect_pc !== m_pc) begin
                errors++; $display("FAIL rand_pc[%0d]: got %h want %h", i, redirect_pc, m_pc);
            end
`ifdef FLUSH_CONTROLLER_STATS_EN
            checks++; if (flush_count !== m_flushes) begin
                errors++; $display("FAIL rand_fcount[%0d]: got %0d want %0d", i, flush_count, m_flushes);
            end
`endif
            model_step();
            tick();
        end
        clear_inputs();
    endtask

`ifdef FLUSH_CONTROLLER_STATS_EN
    task automatic test_stats;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wb_exception_valid = 1'b1;
            tick();
            wb_exception_valid = 1'b0;
            tick();
            redirect_ready = 1'b1;
            tick();
            redirect_ready = 1'b0;
        end
        settle();
        checks++; if (flush_count !== 32'd5) begin
            errors++; $display("FAIL stats_five: got %0d want 5", flush_count);
        end
        wb_eret_flush = 1'b1;
        tick();
        wb_eret_flush = 1'b0;
        tick();
        wb_exception_valid = 1'b1;
        settle();
        checks++; if (pipeline_flush !== 1'b0 || redirect_valid !== 1'b1) begin
            errors++; $display("FAIL stats_ignored: got flush=%b rv=%b want 0 1", pipeline_flush, redirect_valid);
        end
        tick();
        wb_exception_valid = 1'b0;
        settle();
        checks++; if (flush_count !== 32'd6) begin
            errors++; $display("FAIL stats_six: got %0d want 6", flush_count);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_exception();
        test_eret_drain();
        test_both_events();
        test_full();
        test_async_reset();
`ifdef FLUSH_CONTROLLER_STATS_EN
        test_stats();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
